// File: rtl/cache_controller_dm_pkg.sv
// Shared types and address helpers for the direct-mapped read-only cache.
// Field widths are derived from the cache geometry.
package cache_controller_dm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } fsm_state_e;

  function automatic int unsigned calc_off_len(input int unsigned words_per_block);
    return $clog2(words_per_block);
  endfunction

  function automatic int unsigned calc_idx_len(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned calc_tag_len(input int unsigned addr_len,
                                               input int unsigned words_per_block,
                                               input int unsigned num_lines);
    return addr_len - $clog2(num_lines) - $clog2(words_per_block);
  endfunction

  // Right-justified bit field of a word address; callers cast to the field width.
  function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned len);
    return (addr >> lsb) & ((32'd1 << len) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_controller_dm_if.sv
// CPU, refill-memory, maintenance and statistics signals of the cache.
// slave is the cache side, master the CPU/memory side.
interface cache_controller_dm_if #(
  parameter int unsigned ADDR_LEN        = 15,
  parameter int unsigned WORD_LEN        = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned CNT_LEN         = 32
);
  localparam int unsigned BLK_LEN = ADDR_LEN - $clog2(WORDS_PER_BLOCK);

  logic                cpu_rd;
  logic [ADDR_LEN-1:0] cpu_addr;
  logic [WORD_LEN-1:0] cpu_rdata;
  logic                cpu_valid;
  logic                cpu_busy;
  logic                inv;
  logic [ADDR_LEN-1:0] inv_addr;
  logic                flush;
  logic                mem_req;
  logic [BLK_LEN-1:0]  mem_addr;
  logic                mem_rvalid;
  logic [WORD_LEN-1:0] mem_rdata;
  logic [CNT_LEN-1:0]  hit_count;
  logic [CNT_LEN-1:0]  miss_count;

  modport slave (
    input  cpu_rd, cpu_addr, inv, inv_addr, flush, mem_rvalid, mem_rdata,
    output cpu_rdata, cpu_valid, cpu_busy, mem_req, mem_addr, hit_count, miss_count
  );

  modport master (
    output cpu_rd, cpu_addr, inv, inv_addr, flush, mem_rvalid, mem_rdata,
    input  cpu_rdata, cpu_valid, cpu_busy, mem_req, mem_addr, hit_count, miss_count
  );

endinterface

// File: rtl/cache_controller_dm_line_store.sv
// Valid/tag/data arrays of the cache: one combinational read port, one
// whole-line write port, per-index clear and global clear.
module cache_line_store
  import cache_controller_dm_pkg::*;
#(
  parameter  int unsigned WORD_LEN        = 32,
  parameter  int unsigned WORDS_PER_BLOCK = 4,
  parameter  int unsigned NUM_LINES       = 1024,
  parameter  int unsigned TAG_LEN         = 3,
  localparam int unsigned OFF_LEN         = calc_off_len(WORDS_PER_BLOCK),
  localparam int unsigned IDX_LEN         = calc_idx_len(NUM_LINES)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [IDX_LEN-1:0]                        rd_idx,
  input  logic [OFF_LEN-1:0]                        rd_off,
  output logic                                      rd_valid,
  output logic [TAG_LEN-1:0]                        rd_tag,
  output logic [WORD_LEN-1:0]                       rd_word,
  input  logic                                      wr_en,
  input  logic [IDX_LEN-1:0]                        wr_idx,
  input  logic [TAG_LEN-1:0]                        wr_tag,
  input  logic                                      wr_valid,
  input  logic [WORDS_PER_BLOCK-1:0][WORD_LEN-1:0]  wr_line,
  input  logic                                      clr_en,
  input  logic [IDX_LEN-1:0]                        clr_idx,
  input  logic                                      clr_all
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_LEN-1:0]   tag_mem  [NUM_LINES];
  logic [WORDS_PER_BLOCK-1:0][WORD_LEN-1:0] data_mem [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_word  = data_mem[rd_idx][rd_off];

  // Clears are applied after the install so they win on a collision.
  always_comb begin
    valid_d = valid_q;
    if (wr_en)   valid_d[wr_idx]  = wr_valid;
    if (clr_en)  valid_d[clr_idx] = 1'b0;
    if (clr_all) valid_d          = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/cache_controller_dm.sv
// Direct-mapped read-only cache: lookup, burst refill FSM, line invalidate,
// flush and saturating hit/miss statistics.
//
//   state   | meaning
//   IDLE    | accept lookups; hits answered next cycle
//   REFILL  | miss outstanding, collecting refill beats into the line buffer
//   RESPOND | requested word on cpu_rdata for one cycle; also accepts lookups
module cache_controller_dm
  import cache_controller_dm_pkg::*;
#(
  parameter int unsigned ADDR_LEN        = 15,
  parameter int unsigned WORD_LEN        = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned NUM_LINES       = 1024,
  parameter int unsigned CNT_LEN         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_controller_dm_if.slave bus
);

  localparam int unsigned OFF_LEN = calc_off_len(WORDS_PER_BLOCK);
  localparam int unsigned IDX_LEN = calc_idx_len(NUM_LINES);
  localparam int unsigned TAG_LEN = calc_tag_len(ADDR_LEN, WORDS_PER_BLOCK, NUM_LINES);
  localparam int unsigned BLK_LEN = ADDR_LEN - OFF_LEN;

  typedef logic [WORDS_PER_BLOCK-1:0][WORD_LEN-1:0] line_t;

  fsm_state_e          state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [OFF_LEN-1:0]  beat_q, beat_d;
  line_t               buf_q, buf_d;
  logic                kill_q, kill_d;
  logic [WORD_LEN-1:0] rdata_q, rdata_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                req_q, req_d;
  logic [BLK_LEN-1:0]  mem_addr_q, mem_addr_d;
  logic [CNT_LEN-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_LEN-1:0]  miss_cnt_q, miss_cnt_d;

  logic [OFF_LEN-1:0]  lk_off, rf_off;
  logic [IDX_LEN-1:0]  lk_idx, rf_idx, inv_idx;
  logic [TAG_LEN-1:0]  lk_tag, rf_tag;
  logic                st_valid;
  logic [TAG_LEN-1:0]  st_tag;
  logic [WORD_LEN-1:0] st_word;
  logic                lk_kill, rf_kill, hit;
  logic                wr_en;
  line_t               line_w;

  assign lk_off  = OFF_LEN'(addr_field(32'(bus.cpu_addr), 0, OFF_LEN));
  assign lk_idx  = IDX_LEN'(addr_field(32'(bus.cpu_addr), OFF_LEN, IDX_LEN));
  assign lk_tag  = TAG_LEN'(addr_field(32'(bus.cpu_addr), OFF_LEN + IDX_LEN, TAG_LEN));
  assign rf_off  = OFF_LEN'(addr_field(32'(addr_q), 0, OFF_LEN));
  assign rf_idx  = IDX_LEN'(addr_field(32'(addr_q), OFF_LEN, IDX_LEN));
  assign rf_tag  = TAG_LEN'(addr_field(32'(addr_q), OFF_LEN + IDX_LEN, TAG_LEN));
  assign inv_idx = IDX_LEN'(addr_field(32'(bus.inv_addr), OFF_LEN, IDX_LEN));

  // A same-cycle invalidate of the looked-up line turns a would-be hit into a miss.
  assign lk_kill = bus.flush || (bus.inv && (inv_idx == lk_idx));
  assign rf_kill = bus.flush || (bus.inv && (inv_idx == rf_idx));
  assign hit     = st_valid && (st_tag == lk_tag) && !lk_kill;

  cache_line_store #(
    .WORD_LEN        (WORD_LEN),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .NUM_LINES       (NUM_LINES),
    .TAG_LEN         (TAG_LEN)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lk_idx),
    .rd_off   (lk_off),
    .rd_valid (st_valid),
    .rd_tag   (st_tag),
    .rd_word  (st_word),
    .wr_en    (wr_en),
    .wr_idx   (rf_idx),
    .wr_tag   (rf_tag),
    .wr_valid (!(kill_q || rf_kill)),
    .wr_line  (line_w),
    .clr_en   (bus.inv),
    .clr_idx  (inv_idx),
    .clr_all  (bus.flush)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    buf_d      = buf_q;
    kill_d     = kill_q;
    rdata_d    = rdata_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    req_d      = req_q;
    mem_addr_d = mem_addr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wr_en      = 1'b0;
    line_w     = buf_q;
    line_w[WORDS_PER_BLOCK-1] = bus.mem_rdata;

    case (state_q)
      IDLE, RESPOND: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
        if (bus.cpu_rd) begin
          if (hit) begin
            valid_d = 1'b1;
            rdata_d = st_word;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_LEN'(1);
          end else begin
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_LEN'(1);
            state_d    = REFILL;
            addr_d     = bus.cpu_addr;
            mem_addr_d = bus.cpu_addr[ADDR_LEN-1:OFF_LEN];
            beat_d     = '0;
            kill_d     = 1'b0;
            busy_d     = 1'b1;
            req_d      = 1'b1;
          end
        end
      end
      REFILL: begin
        if (rf_kill) kill_d = 1'b1;
        if (bus.mem_rvalid) begin
          buf_d[beat_q] = bus.mem_rdata;
          beat_d        = beat_q + OFF_LEN'(1);
          if (beat_q == OFF_LEN'(WORDS_PER_BLOCK - 1)) begin
            wr_en   = 1'b1;
            state_d = RESPOND;
            req_d   = 1'b0;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            rdata_d = line_w[rf_off];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      buf_q      <= '0;
      kill_q     <= 1'b0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      buf_q      <= buf_d;
      kill_q     <= kill_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      req_q      <= req_d;
      mem_addr_q <= mem_addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_valid  = valid_q;
  assign bus.cpu_busy   = busy_q;
  assign bus.mem_req    = req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

endmodule
